chi_inverse: RTL

Inverse-chi engine for the Keccak slice-organised state memory. On `start` it walks all slices: reads each 25-bit slice, replaces every 5-bit row with its chi preimage, and writes the result back to the same address. It drives the same memory port as the forward chi stage. Running it after that stage restores the original state, and it is used for round-trip checking of the permutation datapath.

---
 rtl/keccak_pkg.sv | 44 ++++
 rtl/chi_inverse_if.sv | 30 +++
 rtl/chi_inverse_chi_inv_slice.sv | 17 +
 rtl/chi_inverse.sv | 111 +++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak slice definitions: row/slice types, the forward chi row
// function and the chi inverse table derived from it.
package keccak_pkg;

  localparam int ROW_W               = 5;
  localparam int SLICE_W             = 25;
  localparam int SLICE_COUNT_DEFAULT = 64;
  localparam int ROWS_PER_SLICE      = SLICE_W / ROW_W;
  localparam int ROW_VALUES          = 1 << ROW_W;

  // Lane x of a row is bit x; row y of a slice is bits 5y..5y+4.
  typedef logic [0:ROW_W-1]   row_t;
  typedef logic [0:SLICE_W-1] slice_t;
  typedef logic [ROW_VALUES-1:0][0:ROW_W-1] chi_lut_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } chi_inv_state_e;

  function automatic row_t chi_row(input row_t a);
    row_t b;
    for (int x = 0; x < ROW_W; x++) begin
      b[x] = a[x] ^ (~a[(x + 1) % ROW_W] & a[(x + 2) % ROW_W]);
    end
    return b;
  endfunction

  // chi is a bijection on 5 bits, so scattering every a to slot chi(a) fills the table.
  function automatic chi_lut_t build_chi_inv_lut();
    chi_lut_t lut;
    lut = '0;
    for (int v = 0; v < ROW_VALUES; v++) begin
      lut[chi_row(row_t'(v))] = row_t'(v);
    end
    return lut;
  endfunction

  localparam chi_lut_t CHI_INV_LUT = build_chi_inv_lut();

endpackage

// File: rtl/chi_inverse_if.sv
// Slice memory port shared by the forward chi stage and the inverse engine.
interface chi_inverse_if
  import keccak_pkg::*;
#(
  parameter int ADR_W = 6
);

  logic [ADR_W-1:0] mem_adr;
  slice_t           mem_in;
  logic             mem_r;
  logic             mem_w;
  slice_t           in;

  modport master (
    output mem_adr,
    output mem_in,
    output mem_r,
    output mem_w,
    input  in
  );

  modport slave (
    input  mem_adr,
    input  mem_in,
    input  mem_r,
    input  mem_w,
    output in
  );

endinterface

// File: rtl/chi_inverse_chi_inv_slice.sv
// Combinational chi inverse of one 25-bit slice: five independent row lookups.
module chi_inv_slice
  import keccak_pkg::*;
(
  input  slice_t slice_i,
  output slice_t slice_o
);

  // Row lookup through the package inverse table.
  always_comb begin
    slice_o = '0;
    for (int y = 0; y < ROWS_PER_SLICE; y++) begin
      slice_o[ROW_W*y +: ROW_W] = CHI_INV_LUT[slice_i[ROW_W*y +: ROW_W]];
    end
  end

endmodule

// File: rtl/chi_inverse.sv
// Inverse-chi engine: walks every slice read/capture/write and replaces each
// row with its chi preimage in place.
module chi_inverse
  import keccak_pkg::*;
#(
  parameter int SLICE_COUNT = SLICE_COUNT_DEFAULT,
  parameter int ADR_W       = 6
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  chi_inverse_if.master    mem
);

  localparam logic [ADR_W-1:0] SLICE_LAST = ADR_W'(SLICE_COUNT - 1);

  chi_inv_state_e   state_q,   state_d;
  logic [ADR_W-1:0] slice_q,   slice_d;
  logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
  slice_t           mem_in_q,  mem_in_d;
  logic             mem_r_q,   mem_r_d;
  logic             mem_w_q,   mem_w_d;
  logic             done_q,    done_d;
  slice_t           inv_s;

  chi_inv_slice u_inv (
    .slice_i (mem.in),
    .slice_o (inv_s)
  );

  // Next state, slice counter and captured write data.
  always_comb begin
    state_d  = state_q;
    slice_d  = slice_q;
    mem_in_d = mem_in_q;
    case (state_q)
      ST_IDLE: begin
        slice_d = {ADR_W{1'b0}};
        if (start) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        mem_in_d = inv_s;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        if (slice_q == SLICE_LAST) begin
          state_d = ST_DONE;
        end else begin
          slice_d = slice_q + ADR_W'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
          slice_d = {ADR_W{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        slice_d = {ADR_W{1'b0}};
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    mem_r_d   = (state_d == ST_READ);
    mem_w_d   = (state_d == ST_WRITE);
    done_d    = (state_d == ST_DONE);
    mem_adr_d = slice_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      slice_q   <= {ADR_W{1'b0}};
      mem_adr_q <= {ADR_W{1'b0}};
      mem_in_q  <= '0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slice_q   <= slice_d;
      mem_adr_q <= mem_adr_d;
      mem_in_q  <= mem_in_d;
      mem_r_q   <= mem_r_d;
      mem_w_q   <= mem_w_d;
      done_q    <= done_d;
    end
  end

  assign mem.mem_adr = mem_adr_q;
  assign mem.mem_in  = mem_in_q;
  assign mem.mem_r   = mem_r_q;
  assign mem.mem_w   = mem_w_q;
  assign done        = done_q;

endmodule
